// File: rtl/lab3_pkg.sv
// Shared types and line levels for the lab3 serial transmitter.
package lab3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/lab3_serial_tx_if.sv
// Load handshake and serial line bundle between a word source and lab3_serial_tx.
interface lab3_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             ready;
    logic             d_out;
    logic             d_out_b;
    logic             busy;
    logic             done;

    modport master (
        output data_in, load,
        input  ready, d_out, d_out_b, busy, done
    );

    modport slave (
        input  data_in, load,
        output ready, d_out, d_out_b, busy, done
    );
endinterface

// File: rtl/lab3_piso_shift.sv
// Parallel-in serial-out register: parallel load, left shift with zero fill.
module lab3_piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load_en) begin
            q <= par_in;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/lab3_serial_tx.sv
// Framed serial transmitter: start, data MSB-first, optional even parity, stop.
// The line is registered and only moves on the rising edge.
module lab3_serial_tx
    import lab3_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clock,
    input  logic             rst_n,
    lab3_serial_tx_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    tx_state_t        state;
    logic [CNT_W-1:0] bit_cnt;
    logic             parity_acc;
    logic [WIDTH-1:0] shift_q;
    logic             accept;
    logic             line_next;

    assign bus.ready = (state == IDLE) || (state == STOP);
    assign bus.done  = (state == STOP);
    assign bus.busy  = (state != IDLE);
    assign accept    = bus.load && bus.ready;

    lab3_piso_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clock    (clock),
        .rst_n    (rst_n),
        .load_en  (accept),
        .shift_en (state == DATA),
        .par_in   (bus.data_in),
        .q        (shift_q)
    );

    // Level the line takes after the coming edge. In DATA the register shifts
    // on that edge, so the next bit out is the one just below the MSB.
    // NOTE: line_next gets a default before the case so no path infers a latch.
    always_comb begin
        line_next = LINE_IDLE;
        case (state)
            IDLE:   line_next = accept ? START_BIT : LINE_IDLE;
            START:  line_next = shift_q[WIDTH-1];
            DATA: begin
                if (bit_cnt == '0) begin
                    line_next = PARITY_EN ? (parity_acc ^ shift_q[WIDTH-1]) : STOP_BIT;
                end else begin
                    line_next = shift_q[WIDTH-2];
                end
            end
            PARITY: line_next = STOP_BIT;
            STOP:   line_next = accept ? START_BIT : LINE_IDLE;
            default: line_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            parity_acc <= 1'b0;
            bus.d_out   <= LINE_IDLE;
            bus.d_out_b <= ~LINE_IDLE;
        end else begin
            bus.d_out   <= line_next;
            bus.d_out_b <= ~line_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= START;
                        parity_acc <= 1'b0;
                    end
                end
                START: begin
                    state   <= DATA;
                    bit_cnt <= CNT_W'(WIDTH - 1);
                end
                DATA: begin
                    parity_acc <= parity_acc ^ shift_q[WIDTH-1];
                    if (bit_cnt == '0) begin
                        state <= PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                PARITY: state <= STOP;
                STOP: begin
                    // A load here chains the next frame with no idle gap.
                    if (accept) begin
                        state      <= START;
                        parity_acc <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab3_serial_tx.sv
// Scoreboard bench for lab3_serial_tx: one instance without parity, one with.
module tb_lab3_serial_tx;

    localparam int W      = 8;
    localparam int FRAME0 = W + 2;
    localparam int FRAME1 = W + 3;

    typedef struct packed {
        logic line;
        logic done;
    } bit_t;

    logic clock = 1'b0;
    logic rst_n = 1'b1;

    int checks   = 0;
    int failures = 0;

    bit_t       q0[$];
    bit_t       q1[$];
    logic [7:0] rx_exp[$];

    logic       rx_q;
    logic       rx_qb;
    int         rx_phase = 0;
    logic [7:0] rx_word;

    lab3_serial_tx_if #(.WIDTH(W)) if0 ();
    lab3_serial_tx_if #(.WIDTH(W)) if1 ();

    lab3_serial_tx #(.WIDTH(W), .PARITY_EN(1'b0)) dut0 (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    lab3_serial_tx #(.WIDTH(W), .PARITY_EN(1'b1)) dut1 (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input int inst, input logic [7:0] w);
        bit_t f[$];
        f.push_back('{line: 1'b0, done: 1'b0});
        for (int i = W - 1; i >= 0; i--) f.push_back('{line: w[i], done: 1'b0});
        if (inst == 1) f.push_back('{line: ^w, done: 1'b0});
        f.push_back('{line: 1'b1, done: 1'b1});
        foreach (f[i]) begin
            if (inst == 0) q0.push_back(f[i]);
            else           q1.push_back(f[i]);
        end
    endtask

    // One-cycle load pulse; a frame is expected only when the bench
    // knows the transmitter is ready for it.
    task automatic send(input int inst, input logic [7:0] w, input bit accept);
        @(negedge clock); #1;
        if (inst == 0) begin
            if0.data_in = w;
            if0.load    = 1'b1;
        end else begin
            if1.data_in = w;
            if1.load    = 1'b1;
        end
        if (accept) begin
            push_frame(inst, w);
            if (inst == 0) rx_exp.push_back(w);
        end
        @(negedge clock); #1;
        if0.load = 1'b0;
        if1.load = 1'b0;
    endtask

    // Line monitors: compare every mid-cycle sample against the scoreboard,
    // or against the idle line when no frame is expected.
    always @(negedge clock) begin
        if (q0.size() > 0) begin
            check("p0_line",  if0.d_out,   q0[0].line);
            check("p0_lineb", if0.d_out_b, 1'(~q0[0].line));
            check("p0_done",  if0.done,    q0[0].done);
            check("p0_ready", if0.ready,   q0[0].done);
            check("p0_busy",  if0.busy,    1'b1);
            void'(q0.pop_front());
        end else begin
            check("p0_idle_line",  if0.d_out,   1'b1);
            check("p0_idle_lineb", if0.d_out_b, 1'b0);
            check("p0_idle_ready", if0.ready,   1'b1);
            check("p0_idle_busy",  if0.busy,    1'b0);
            check("p0_idle_done",  if0.done,    1'b0);
        end
    end

    always @(negedge clock) begin
        if (q1.size() > 0) begin
            check("p1_line",  if1.d_out,   q1[0].line);
            check("p1_lineb", if1.d_out_b, 1'(~q1[0].line));
            check("p1_done",  if1.done,    q1[0].done);
            check("p1_ready", if1.ready,   q1[0].done);
            check("p1_busy",  if1.busy,    1'b1);
            void'(q1.pop_front());
        end else begin
            check("p1_idle_line",  if1.d_out,   1'b1);
            check("p1_idle_lineb", if1.d_out_b, 1'b0);
            check("p1_idle_ready", if1.ready,   1'b1);
            check("p1_idle_busy",  if1.busy,    1'b0);
            check("p1_idle_done",  if1.done,    1'b0);
        end
    end

    // Negative-edge receiving flop on instance 0's line.
    always @(negedge clock) begin
        rx_q  <= if0.d_out;
        rx_qb <= if0.d_out_b;
    end

    // Frame decoder working from the flop outputs on the following rising edge.
    always @(posedge clock) begin
        if (!rst_n) begin
            rx_phase <= 0;
        end else begin
            check("rx_qb", rx_qb, 1'(~rx_q));
            if (rx_phase == 0) begin
                if (rx_q == 1'b0) rx_phase <= 1;
            end else if (rx_phase <= W) begin
                rx_word  <= {rx_word[6:0], rx_q};
                rx_phase <= rx_phase + 1;
            end else begin
                check("rx_stop", rx_q, 1'b1);
                check("rx_pending", 32'(rx_exp.size() > 0), 1);
                if (rx_exp.size() > 0) begin
                    check("rx_word", rx_word, rx_exp[0]);
                    void'(rx_exp.pop_front());
                end
                rx_phase <= 0;
            end
        end
    end

    initial begin
        if0.load    = 1'b0;
        if0.data_in = '0;
        if1.load    = 1'b0;
        if1.data_in = '0;

        // Power-on reset held for two cycles.
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_line",  if0.d_out,   1'b1);
        check("rst_lineb", if0.d_out_b, 1'b0);
        check("rst_ready", if0.ready,   1'b1);
        check("rst_busy",  if0.busy,    1'b0);
        check("rst_done",  if1.done,    1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);

        // Single frames, with and without parity.
        send(0, 8'hA5, 1'b1);
        repeat (FRAME0) @(negedge clock);
        send(1, 8'hA5, 1'b1);
        repeat (FRAME1) @(negedge clock);
        send(1, 8'h07, 1'b1);
        repeat (FRAME1) @(negedge clock);

        // Back-to-back: second load lands in the STOP cycle.
        send(0, 8'hFF, 1'b1);
        repeat (FRAME0 - 2) @(negedge clock);
        send(0, 8'h00, 1'b1);
        repeat (FRAME0) @(negedge clock);
        send(1, 8'h81, 1'b1);
        repeat (FRAME1 - 2) @(negedge clock);
        send(1, 8'h7E, 1'b1);
        repeat (FRAME1) @(negedge clock);

        // Load during DATA must be ignored.
        send(0, 8'hC3, 1'b1);
        repeat (2) @(negedge clock);
        send(0, 8'h3C, 1'b0);
        repeat (FRAME0 + 2) @(negedge clock);

        // Reset during DATA bit 3: the line goes idle at once and stays idle.
        send(0, 8'h5A, 1'b1);
        repeat (5) @(negedge clock);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_line",  if0.d_out,   1'b1);
        check("midrst_lineb", if0.d_out_b, 1'b0);
        check("midrst_busy",  if0.busy,    1'b0);
        q0.delete();
        rx_exp.delete();
        repeat (2) @(negedge clock);
        #1 rst_n = 1'b1;
        repeat (FRAME0 + 2) @(negedge clock);

        // Loopback of random words, streamed back-to-back.
        for (int i = 0; i < 20; i++) begin
            send(0, 8'($urandom), 1'b1);
            repeat (FRAME0 - 2) @(negedge clock);
        end
        repeat (4) @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            send(1, 8'($urandom), 1'b1);
            repeat (FRAME1 - 2) @(negedge clock);
        end
        repeat (6) @(negedge clock);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("rx_drained", rx_exp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
